// File: rtl/dff_write_arbiter.sv
// rtl/dff_write_arbiter.sv - round-robin arbiter granting N_REQ writers access to one shared register
// Each write is followed by a fixed hold-off window before the next arbitration.
module dff_write_arbiter #(
    parameter int N_REQ       = 4,
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int OW = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] d,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       q,
    output logic                   q_valid,
    output logic [OW-1:0]          owner,
    output logic                   busy
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LAST = (HOLD_CYCLES > 0) ? CW'(HOLD_CYCLES - 1) : '0;

    typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

    state_t           state, state_nxt;
    logic [OW-1:0]    ptr, ptr_nxt;
    logic [OW-1:0]    win, win_nxt;
    logic [OW-1:0]    owner_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [N_REQ-1:0] gnt_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             q_valid_nxt, busy_nxt;
    logic [OW-1:0]    cand, scan_idx;
    logic             scan_hit;
    logic [WIDTH-1:0] dv [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign dv[g] = d[g*WIDTH +: WIDTH];
    end

    // Walk downward so the nearest requester after ptr is the one that sticks.
    always_comb begin
        scan_hit = 1'b0;
        scan_idx = '0;
        cand     = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = OW'((int'(ptr) + i) % N_REQ);
            if (req[cand]) begin
                scan_hit = 1'b1;
                scan_idx = cand;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        win_nxt     = win;
        owner_nxt   = owner;
        cnt_nxt     = cnt;
        gnt_nxt     = '0;
        q_nxt       = q;
        q_valid_nxt = 1'b0;
        busy_nxt    = busy;
        case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (scan_hit) begin
                    state_nxt = GRANT;
                    win_nxt   = scan_idx;
                    gnt_nxt   = N_REQ'(1) << scan_idx;
                    busy_nxt  = 1'b1;
                end
            end
            GRANT: begin
                if (req[win]) begin
                    q_nxt       = dv[win];
                    q_valid_nxt = 1'b1;
                    owner_nxt   = win;
                    ptr_nxt     = win;
                    if (HOLD_CYCLES == 0) begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                    end else begin
                        state_nxt = HOLD;
                        busy_nxt  = 1'b1;
                        cnt_nxt   = HOLD_LAST;
                    end
                end else begin
                    // Writer withdrew: abandon the slot without a hold-off.
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= OW'(N_REQ - 1);
            win     <= '0;
            owner   <= '0;
            cnt     <= '0;
            gnt     <= '0;
            q       <= RST_VAL;
            q_valid <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            win     <= win_nxt;
            owner   <= owner_nxt;
            cnt     <= cnt_nxt;
            gnt     <= gnt_nxt;
            q       <= q_nxt;
            q_valid <= q_valid_nxt;
            busy    <= busy_nxt;
        end
    end

endmodule
